// File: rtl/switch_sequencer.sv
// Break-before-make sequencer for the RF switch bank. Each switch-state command drives the
// switch lines, waits for settle, triggers the VNA and then waits for the acquisition-ready edge.
module switch_sequencer #(
    parameter int BBM_CYCLES     = 500,
    parameter int SETTLE_CYCLES  = 50000,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_state,
    input  logic       acq_rdy,
    output logic [2:0] sw_ctrl,
    output logic       vna_trig,
    output logic [1:0] cur_state,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       cmd_err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BREAK    = 3'd1,
        S_SETTLE   = 3'd2,
        S_TRIG     = 3'd3,
        S_WAIT_RDY = 3'd4
    } state_t;

    // Load values are PARAM-1; a zero parameter still gives a one-cycle interval.
    localparam logic [CNT_W-1:0] L_BBM     = (BBM_CYCLES     > 0) ? CNT_W'(BBM_CYCLES - 1)     : '0;
    localparam logic [CNT_W-1:0] L_SETTLE  = (SETTLE_CYCLES  > 0) ? CNT_W'(SETTLE_CYCLES - 1)  : '0;
    localparam logic [CNT_W-1:0] L_TRIG    = (TRIG_CYCLES    > 0) ? CNT_W'(TRIG_CYCLES - 1)    : '0;
    localparam logic [CNT_W-1:0] L_TIMEOUT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_target, w_target_nxt;
    logic [2:0]       r_sw, w_sw_nxt;
    logic [1:0]       r_cur, w_cur_nxt;
    logic             r_trig, w_trig_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_cmd_err, w_cmd_err_nxt;
    logic             r_acq_s1, r_acq_s2, r_acq_s3;
    logic             w_rdy_rise;

    assign w_rdy_rise = r_acq_s2 & ~r_acq_s3;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
        w_target_nxt  = r_target;
        w_sw_nxt      = r_sw;
        w_cur_nxt     = r_cur;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        w_cmd_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_state == 2'd3) begin
                        w_cmd_err_nxt = 1'b1;
                    end else if (cmd_state == r_cur) begin
                        w_state_nxt = S_TRIG;
                        w_cnt_nxt   = L_TRIG;
                    end else begin
                        w_state_nxt  = S_BREAK;
                        w_cnt_nxt    = L_BBM;
                        w_sw_nxt     = 3'b000;
                        w_target_nxt = cmd_state;
                    end
                end
            end
            S_BREAK: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = L_SETTLE;
                    w_sw_nxt    = 3'b001 << r_target;
                    w_cur_nxt   = r_target;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_TRIG;
                    w_cnt_nxt   = L_TRIG;
                end
            end
            S_TRIG: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WAIT_RDY;
                    w_cnt_nxt   = L_TIMEOUT;
                end
            end
            S_WAIT_RDY: begin
                // A ready edge on the final timeout cycle still counts as a completed acquisition.
                if (w_rdy_rise) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (cmd_valid && (r_state != S_IDLE)) begin
            w_cmd_err_nxt = 1'b1;
        end
        w_trig_nxt = (w_state_nxt == S_TRIG);
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_target  <= 2'd0;
            r_sw      <= 3'b001;
            r_cur     <= 2'd0;
            r_trig    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_cmd_err <= 1'b0;
            r_acq_s1  <= 1'b0;
            r_acq_s2  <= 1'b0;
            r_acq_s3  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_target  <= w_target_nxt;
            r_sw      <= w_sw_nxt;
            r_cur     <= w_cur_nxt;
            r_trig    <= w_trig_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_cmd_err <= w_cmd_err_nxt;
            r_acq_s1  <= acq_rdy;
            r_acq_s2  <= r_acq_s1;
            r_acq_s3  <= r_acq_s2;
        end
    end

    assign sw_ctrl   = r_sw;
    assign vna_trig  = r_trig;
    assign cur_state = r_cur;
    assign busy      = r_busy;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign cmd_err   = r_cmd_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer with short intervals (BBM=2, SETTLE=4, TRIG=3, TIMEOUT=20).
// Cycle c is the interval after the c-th rising edge; a command driven in cycle 0 is sampled by edge 1.
module tb_switch_sequencer;

    logic       clk_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_state = 2'd0;
    logic       acq_rdy = 1'b0;
    logic [2:0] sw_ctrl;
    logic       vna_trig;
    logic [1:0] cur_state;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       cmd_err;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    switch_sequencer #(
        .BBM_CYCLES(2), .SETTLE_CYCLES(4), .TRIG_CYCLES(3), .TIMEOUT_CYCLES(20), .CNT_W(26)
    ) dut (
        .clk_50(clk_50), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_state(cmd_state),
        .acq_rdy(acq_rdy), .sw_ctrl(sw_ctrl), .vna_trig(vna_trig), .cur_state(cur_state),
        .busy(busy), .done(done), .timeout(timeout), .cmd_err(cmd_err), .dbg_state(dbg_state)
    );

    always #5 clk_50 = ~clk_50;

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (sw_ctrl !== 3'b001 || vna_trig !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_held: sw=%b trig=%b busy=%b, need 001/0/0", sw_ctrl, vna_trig, busy);
        end
        @(negedge clk_50);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_checks++;
            if (sw_ctrl !== 3'b001 || cur_state !== 2'd0 || busy !== 1'b0 || vna_trig !== 1'b0 ||
                done !== 1'b0 || timeout !== 1'b0 || cmd_err !== 1'b0 || dbg_state !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_idle c%0d: sw=%b cur=%0d busy=%b trig=%b done=%b to=%b err=%b st=%0d",
                         c, sw_ctrl, cur_state, busy, vna_trig, done, timeout, cmd_err, dbg_state);
            end
        end
    endtask

    task automatic test_new_path();
        logic [2:0] exp_sw;
        logic [1:0] exp_cur;
        cmd_valid = 1'b1;
        cmd_state = 2'd2;
        for (int c = 1; c <= 17; c++) begin
            tick();
            cmd_valid = 1'b0;
            acq_rdy = (c >= 12 && c <= 14);
            exp_sw  = (c <= 2) ? 3'b000 : 3'b100;
            exp_cur = (c <= 2) ? 2'd0 : 2'd2;
            n_checks++;
            if (sw_ctrl !== exp_sw || cur_state !== exp_cur) begin
                n_errors++;
                $display("FAIL new_path_sw c%0d: sw=%b cur=%0d, need %b/%0d", c, sw_ctrl, cur_state, exp_sw, exp_cur);
            end
            n_checks++;
            if (vna_trig !== (c >= 7 && c <= 9) || busy !== (c < 15) || done !== (c == 15)) begin
                n_errors++;
                $display("FAIL new_path_ctl c%0d: trig=%b busy=%b done=%b, need %b/%b/%b",
                         c, vna_trig, busy, done, (c >= 7 && c <= 9), (c < 15), (c == 15));
            end
        end
    endtask

    task automatic test_same_state();
        cmd_valid = 1'b1;
        cmd_state = 2'd2;
        for (int c = 1; c <= 10; c++) begin
            tick();
            cmd_valid = 1'b0;
            acq_rdy = (c >= 5 && c <= 7);
            n_checks++;
            if (sw_ctrl !== 3'b100 || vna_trig !== (c <= 3) || busy !== (c < 8) || done !== (c == 8)) begin
                n_errors++;
                $display("FAIL same_state c%0d: sw=%b trig=%b busy=%b done=%b, need 100/%b/%b/%b",
                         c, sw_ctrl, vna_trig, busy, done, (c <= 3), (c < 8), (c == 8));
            end
        end
    endtask

    task automatic test_timeout();
        acq_rdy = 1'b0;
        cmd_valid = 1'b1;
        cmd_state = 2'd2;
        for (int c = 1; c <= 26; c++) begin
            tick();
            cmd_valid = 1'b0;
            n_checks++;
            if (sw_ctrl !== 3'b100 || done !== 1'b0 || timeout !== (c == 24) || busy !== (c < 24)) begin
                n_errors++;
                $display("FAIL timeout c%0d: sw=%b done=%b to=%b busy=%b, need 100/0/%b/%b",
                         c, sw_ctrl, done, timeout, busy, (c == 24), (c < 24));
            end
        end
    endtask

    task automatic test_cmd_err();
        logic [2:0] exp_sw;
        cmd_valid = 1'b1;
        cmd_state = 2'd3;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (cmd_err !== 1'b1 || busy !== 1'b0 || sw_ctrl !== 3'b100 || cur_state !== 2'd2) begin
            n_errors++;
            $display("FAIL err_invalid: err=%b busy=%b sw=%b cur=%0d, need 1/0/100/2", cmd_err, busy, sw_ctrl, cur_state);
        end
        tick();
        n_checks++;
        if (cmd_err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_invalid_len: err=%b, need 0", cmd_err);
        end
        cmd_valid = 1'b1;
        cmd_state = 2'd0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            cmd_valid = (c == 4);
            cmd_state = (c == 4) ? 2'd1 : 2'd0;
            acq_rdy = (c >= 11 && c <= 13);
            exp_sw = (c <= 2) ? 3'b000 : 3'b001;
            n_checks++;
            if (cmd_err !== (c == 5) || sw_ctrl !== exp_sw || vna_trig !== (c >= 7 && c <= 9) ||
                done !== (c == 14)) begin
                n_errors++;
                $display("FAIL err_busy c%0d: err=%b sw=%b trig=%b done=%b, need %b/%b/%b/%b",
                         c, cmd_err, sw_ctrl, vna_trig, done, (c == 5), exp_sw, (c >= 7 && c <= 9), (c == 14));
            end
        end
        n_checks++;
        if (cur_state !== 2'd0) begin
            n_errors++;
            $display("FAIL err_busy_cur: cur=%0d, need 0", cur_state);
        end
    endtask

    task automatic test_reset_in_trig();
        cmd_valid = 1'b1;
        cmd_state = 2'd1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            cmd_valid = 1'b0;
        end
        n_checks++;
        if (vna_trig !== 1'b1 || sw_ctrl !== 3'b010) begin
            n_errors++;
            $display("FAIL trig_before_rst: trig=%b sw=%b, need 1/010", vna_trig, sw_ctrl);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (vna_trig !== 1'b0 || sw_ctrl !== 3'b001 || cur_state !== 2'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: trig=%b sw=%b cur=%0d busy=%b, need 0/001/0/0",
                     vna_trig, sw_ctrl, cur_state, busy);
        end
        @(negedge clk_50);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_level_high_entry();
        acq_rdy = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        cmd_valid = 1'b1;
        cmd_state = 2'd0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            cmd_valid = 1'b0;
            acq_rdy = !(c >= 11 && c <= 12);
            n_checks++;
            if (done !== (c == 16) || timeout !== 1'b0 || busy !== (c < 16) || vna_trig !== (c <= 3)) begin
                n_errors++;
                $display("FAIL level_entry c%0d: done=%b to=%b busy=%b trig=%b, need %b/0/%b/%b",
                         c, done, timeout, busy, vna_trig, (c == 16), (c < 16), (c <= 3));
            end
        end
        acq_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_new_path();
        test_same_state();
        test_timeout();
        test_cmd_err();
        test_reset_in_trig();
        test_level_high_entry();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
